// File: rtl/phi_sequencer_pkg.sv
// Shared types and constants for the two-phase clock sequencer.
package phi_seq_pkg;

    typedef enum logic [2:0] {
        ST_HALT = 3'd0,
        ST_P1   = 3'd1,
        ST_G1   = 3'd2,
        ST_P2   = 3'd3,
        ST_G2   = 3'd4
    } state_e;

    localparam int CYC_W = 16;

endpackage

// File: rtl/phi_sequencer_phase_timer.sv
// Loadable down-counter that parks at zero; sets how long each phase/gap lasts.
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/phi_sequencer.sv
// Two-phase non-overlapping PHI1/PHI2 generator with run/halt/single-step control.
module phi_sequencer
    import phi_seq_pkg::*;
#(
    parameter int DIV   = 4,
    parameter int GAP   = 1,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RUN,
    input  logic             STEP,
    output logic             PHI1,
    output logic             PHI2,
    output logic             PHI1_RISE,
    output logic             PHI2_FALL,
    output logic             HALTED,
    output logic [CYC_W-1:0] CYCLE_CNT
);

    if (DIV < 1 || DIV > (2 ** CNT_W) - 1) begin : g_div_check
        $error("phi_sequencer: DIV must be in 1..2**CNT_W-1");
    end
    if (GAP < 0 || GAP > (2 ** CNT_W)) begin : g_gap_check
        $error("phi_sequencer: GAP must be in 0..2**CNT_W");
    end

    localparam logic             NO_GAP = (GAP == 0);
    localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] GAP_M1 = (GAP > 0) ? CNT_W'(GAP - 1) : '0;

    state_e             state_q, state_d;
    logic               step_q;
    logic               pending_q, pending_d;
    logic               phi1_q, phi1_d;
    logic               phi2_q, phi2_d;
    logic               rise_q, rise_d;
    logic               fall_q, fall_d;
    logic               halted_q, halted_d;
    logic [CYC_W-1:0]   cnt_q, cnt_d;
    logic               tmr_load;
    logic [CNT_W-1:0]   tmr_val;
    logic               tmr_zero;
    logic               step_edge;
    logic               cycle_end;

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .CLK      (CLK),
        .RST      (RST),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    assign step_edge = STEP & ~step_q;
    // Last CLK of a CPU cycle: P2 itself when there is no gap, otherwise G2.
    assign cycle_end = tmr_zero && ((state_q == ST_G2) || (NO_GAP && state_q == ST_P2));

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        unique case (state_q)
            ST_HALT: begin
                if (RUN) begin
                    state_d = ST_P1;
                end else if (step_edge) begin
                    state_d   = ST_P1;
                    pending_d = 1'b1;
                end
            end
            ST_P1:   if (tmr_zero) state_d = NO_GAP ? ST_P2 : ST_G1;
            ST_G1:   if (tmr_zero) state_d = ST_P2;
            ST_P2:   if (tmr_zero && !NO_GAP) state_d = ST_G2;
            ST_G2:   ;
            default: state_d = ST_HALT;
        endcase
        if (cycle_end) begin
            state_d   = (RUN && !pending_q) ? ST_P1 : ST_HALT;
            pending_d = 1'b0;
        end

        tmr_load = (state_d != state_q) && (state_d != ST_HALT);
        tmr_val  = (state_d == ST_G1 || state_d == ST_G2) ? GAP_M1 : DIV_M1;

        // Outputs are decoded from the next state so they land in flops alongside it.
        phi1_d   = (state_d == ST_HALT) || (state_d == ST_P1);
        phi2_d   = (state_d == ST_P2);
        halted_d = (state_d == ST_HALT);
        rise_d   = (state_d == ST_P1) && (state_q == ST_G2 || state_q == ST_P2);
        fall_d   = phi2_q && !phi2_d;
        cnt_d    = cnt_q + CYC_W'(fall_d);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_HALT;
            step_q    <= 1'b0;
            pending_q <= 1'b0;
            phi1_q    <= 1'b1;
            phi2_q    <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            halted_q  <= 1'b1;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= STEP;
            pending_q <= pending_d;
            phi1_q    <= phi1_d;
            phi2_q    <= phi2_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            halted_q  <= halted_d;
            cnt_q     <= cnt_d;
        end
    end

    assign PHI1      = phi1_q;
    assign PHI2      = phi2_q;
    assign PHI1_RISE = rise_q;
    assign PHI2_FALL = fall_q;
    assign HALTED    = halted_q;
    assign CYCLE_CNT = cnt_q;

endmodule
